// File: rtl/wb_pkg.sv
// Writeback stage shared definitions: load-kind encoding used by the mem-stage
// decoder and by the writeback load aligner.
package wb_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } load_op_e;

  localparam int LOAD_OP_W = 3;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extraction: picks the addressed byte/half, extends it,
// or merges a partial word with the old rt value for LWL/LWR.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [LOAD_OP_W-1:0] op_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          data_i,
  input  logic [31:0]          rt_old_i,
  output logic [31:0]          result_o
);

  // Big-endian mirrors the byte lane; the half lane follows from the top bit.
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane     = (BIG_ENDIAN != 0) ? ~addr_lo_i : addr_lo_i;
  assign byte_sel = data_i[8*lane +: 8];
  assign half_sel = lane[1] ? data_i[31:16] : data_i[15:0];

  // Select/extend/merge according to the load kind.
  always_comb begin
    result_o = data_i;
    case (load_op_e'(op_i))
      LD_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: result_o = {24'h0, byte_sel};
      LD_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU: result_o = {16'h0, half_sel};
      LD_LWL: begin
        case (lane)
          2'd0:    result_o = {data_i[7:0],  rt_old_i[23:0]};
          2'd1:    result_o = {data_i[15:0], rt_old_i[15:0]};
          2'd2:    result_o = {data_i[23:0], rt_old_i[7:0]};
          default: result_o = data_i;
        endcase
      end
      LD_LWR: begin
        case (lane)
          2'd1:    result_o = {rt_old_i[31:24], data_i[31:8]};
          2'd2:    result_o = {rt_old_i[31:16], data_i[31:16]};
          2'd3:    result_o = {rt_old_i[31:8],  data_i[31:24]};
          default: result_o = data_i;
        endcase
      end
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_param.sv
// MIPS writeback stage: MEM/WB pipeline register, load extraction on the
// registered fields, GPR and HI/LO commit gating, forwarding tap and retire counter.
module wb_stage_param
  import wb_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int RETIRE_CNT_W = 32,
  parameter int HAS_HILO     = 1,
  parameter int BIG_ENDIAN   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    mem_valid,
  input  logic                    mem_reg_we,
  input  logic [REG_ADDR_W-1:0]   mem_reg_waddr,
  input  logic [31:0]             mem_result,
  input  logic [LOAD_OP_W-1:0]    mem_load_op,
  input  logic [31:0]             mem_load_data,
  input  logic [1:0]              mem_addr_lo,
  input  logic [31:0]             mem_rt_old,
  input  logic                    mem_hilo_we,
  input  logic [31:0]             mem_hi,
  input  logic [31:0]             mem_lo,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    hilo_we,
  output logic [31:0]             hi_wdata,
  output logic [31:0]             lo_wdata,
  output logic                    fwd_valid,
  output logic [REG_ADDR_W-1:0]   fwd_addr,
  output logic [31:0]             fwd_data,
  output logic [RETIRE_CNT_W-1:0] retired_cnt
);

  typedef struct packed {
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [31:0]           result;
    logic [LOAD_OP_W-1:0]  load_op;
    logic [31:0]           load_data;
    logic [1:0]            addr_lo;
    logic [31:0]           rt_old;
    logic                  hilo_we;
    logic [31:0]           hi;
    logic [31:0]           lo;
  } wb_reg_t;

  wb_reg_t                 wb_q, wb_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [RETIRE_CNT_W-1:0] ret_q, ret_d;
  logic [31:0]             load_res;

  // Capture: flush kills, stall drops valid (the held op has already committed),
  // otherwise take the MEM stage's instruction.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    if (!flush && !stall) begin
      wb_valid_d     = mem_valid;
      wb_d.reg_we    = mem_reg_we;
      wb_d.waddr     = mem_reg_waddr;
      wb_d.result    = mem_result;
      wb_d.load_op   = mem_load_op;
      wb_d.load_data = mem_load_data;
      wb_d.addr_lo   = mem_addr_lo;
      wb_d.rt_old    = mem_rt_old;
      wb_d.hilo_we   = mem_hilo_we;
      wb_d.hi        = mem_hi;
      wb_d.lo        = mem_lo;
    end
  end

  // Retire counter counts every valid op in WB, including suppressed $0 writes.
  always_comb begin
    ret_d = ret_q;
    if (wb_valid_q) ret_d = ret_q + RETIRE_CNT_W'(1);
  end

  // MEM/WB register and retire counter; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      ret_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      ret_q      <= ret_d;
    end
  end

  wb_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op_i      (wb_q.load_op),
    .addr_lo_i (wb_q.addr_lo),
    .data_i    (wb_q.load_data),
    .rt_old_i  (wb_q.rt_old),
    .result_o  (load_res)
  );

  assign rf_we       = wb_valid_q & wb_q.reg_we & (wb_q.waddr != '0);
  assign rf_waddr    = wb_q.waddr;
  assign rf_wdata    = (load_op_e'(wb_q.load_op) == LD_NONE) ? wb_q.result : load_res;
  assign fwd_valid   = rf_we;
  assign fwd_addr    = rf_waddr;
  assign fwd_data    = rf_wdata;
  assign retired_cnt = ret_q;

  if (HAS_HILO != 0) begin : g_hilo
    assign hilo_we  = wb_valid_q & wb_q.hilo_we;
    assign hi_wdata = wb_q.hi;
    assign lo_wdata = wb_q.lo;
  end else begin : g_no_hilo
    assign hilo_we  = 1'b0;
    assign hi_wdata = 32'h0;
    assign lo_wdata = 32'h0;
  end

endmodule

// File: tb/tb_wb_stage_param.sv
// Scoreboard bench for wb_stage_param: stimulus pushes expected commits, a
// negedge monitor pops and compares whenever a GPR or HI/LO write appears.
module tb_wb_stage_param;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, mem_valid, mem_reg_we, mem_hilo_we;
  logic [4:0]  mem_reg_waddr;
  logic [31:0] mem_result, mem_load_data, mem_rt_old, mem_hi, mem_lo;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;

  logic        rf_we, hilo_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, hi_wdata, lo_wdata, fwd_data, retired_cnt;

  logic        rf_we_b, hilo_we_b, fwd_valid_b;
  logic [4:0]  rf_waddr_b, fwd_addr_b;
  logic [31:0] rf_wdata_b, hi_wdata_b, lo_wdata_b, fwd_data_b;
  logic [3:0]  retired_cnt_b;

  always #5 clk = ~clk;

  wb_stage_param dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr), .mem_result(mem_result),
    .mem_load_op(mem_load_op), .mem_load_data(mem_load_data), .mem_addr_lo(mem_addr_lo),
    .mem_rt_old(mem_rt_old), .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retired_cnt(retired_cnt)
  );

  wb_stage_param #(.RETIRE_CNT_W(4), .HAS_HILO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr), .mem_result(mem_result),
    .mem_load_op(mem_load_op), .mem_load_data(mem_load_data), .mem_addr_lo(mem_addr_lo),
    .mem_rt_old(mem_rt_old), .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b), .hilo_we(hilo_we_b),
    .hi_wdata(hi_wdata_b), .lo_wdata(lo_wdata_b), .fwd_valid(fwd_valid_b), .fwd_addr(fwd_addr_b),
    .fwd_data(fwd_data_b), .retired_cnt(retired_cnt_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_ret    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every visible commit of the main DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (rf_we || hilo_we)) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_commit: rf_we=%0b waddr=%0d wdata=0x%08h hilo_we=%0b, none expected",
                 rf_we, rf_waddr, rf_wdata, hilo_we);
      end else begin
        exp_t e;
        logic bad;
        e   = sb_q.pop_front();
        bad = (rf_we !== e.we) || (hilo_we !== e.hwe) || (fwd_valid !== rf_we);
        if (e.we)  bad = bad || (rf_waddr !== e.waddr) || (rf_wdata !== e.wdata) ||
                         (fwd_addr !== e.waddr) || (fwd_data !== e.wdata);
        if (e.hwe) bad = bad || (hi_wdata !== e.hi) || (lo_wdata !== e.lo);
        if (bad) begin
          mismatched++;
          $display("FAIL commit: got we=%0b a=%0d d=0x%08h fwd=%0b/%0d/0x%08h hwe=%0b hi=0x%08h lo=0x%08h; expected we=%0b a=%0d d=0x%08h hwe=%0b hi=0x%08h lo=0x%08h",
                   rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, hilo_we, hi_wdata, lo_wdata,
                   e.we, e.waddr, e.wdata, e.hwe, e.hi, e.lo);
        end
      end
    end
  end

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] res,
                        input logic [2:0] op, input logic [31:0] data, input logic [1:0] lo2,
                        input logic [31:0] rt, input logic hwe, input logic [31:0] hi,
                        input logic [31:0] lov);
    mem_valid = 1'b1; mem_reg_we = we; mem_reg_waddr = wa; mem_result = res;
    mem_load_op = op; mem_load_data = data; mem_addr_lo = lo2; mem_rt_old = rt;
    mem_hilo_we = hwe; mem_hi = hi; mem_lo = lov;
  endtask

  task automatic push(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic hwe, input logic [31:0] hi, input logic [31:0] lov);
    exp_t e;
    e.we = we && (wa != 5'd0); e.waddr = wa; e.wdata = wd; e.hwe = hwe; e.hi = hi; e.lo = lov;
    if (e.we || e.hwe) sb_q.push_back(e);
  endtask

  // One accepted op; returns 1 time unit into its commit cycle.
  task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] res,
                       input logic [2:0] op, input logic [31:0] data, input logic [1:0] lo2,
                       input logic [31:0] rt, input logic hwe, input logic [31:0] hi,
                       input logic [31:0] lov, input logic [31:0] exp_wd, input bit do_push);
    set_in(we, wa, res, op, data, lo2, rt, hwe, hi, lov);
    if (do_push) push(we, wa, exp_wd, hwe, hi, lov);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    exp_ret++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_ret(input string name);
    chk({name, "_cnt"}, retired_cnt, exp_ret);
    chk({name, "_cnt4"}, {28'h0, retired_cnt_b}, {28'h0, 4'(exp_ret)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    // Reset held with a valid, writing op presented: nothing may leak out.
    set_in(1'b1, 5'd3, 32'h1234_5678, LD_NONE, 32'h0, 2'd0, 32'h0, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002);
    idle(3);
    chk("rst_outputs", {31'h0, rf_we | hilo_we | fwd_valid | (|rf_wdata) | (|hi_wdata) | (|lo_wdata) | (|rf_waddr)}, 32'h0);
    chk("rst_cnt", retired_cnt, 32'h0);
    chk("rst_cnt4", {28'h0, retired_cnt_b}, 32'h0);
    push(1'b1, 5'd3, 32'h1234_5678, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    exp_ret++;
    chk("first_commit_latency", {31'h0, rf_we}, 32'h1);
    chk("first_commit_cnt_before", retired_cnt, 32'h0);
    idle(1);
    chk("first_commit_cnt", retired_cnt, 32'h1);

    // Load extraction vectors.
    issue(1, 5'd5, 32'h0, LD_LB,  32'h80FF_1234, 2'd3, 32'h0, 0, 0, 0, 32'hFFFF_FF80, 1);
    issue(1, 5'd5, 32'h0, LD_LBU, 32'h80FF_1234, 2'd3, 32'h0, 0, 0, 0, 32'h0000_0080, 1);
    issue(1, 5'd5, 32'h0, LD_LH,  32'h80FF_1234, 2'd2, 32'h0, 0, 0, 0, 32'hFFFF_80FF, 1);
    issue(1, 5'd5, 32'h0, LD_LHU, 32'h80FF_1234, 2'd3, 32'h0, 0, 0, 0, 32'h0000_80FF, 1);
    issue(1, 5'd6, 32'h0, LD_LH,  32'h80FF_9234, 2'd1, 32'h0, 0, 0, 0, 32'hFFFF_9234, 1);
    issue(1, 5'd6, 32'h0, LD_LB,  32'h80FF_1234, 2'd0, 32'h0, 0, 0, 0, 32'h0000_0034, 1);
    issue(1, 5'd6, 32'h0, LD_LW,  32'h80FF_1234, 2'd0, 32'h0, 0, 0, 0, 32'h80FF_1234, 1);
    issue(1, 5'd7, 32'h0, LD_LWL, 32'hAABB_CCDD, 2'd1, 32'h1122_3344, 0, 0, 0, 32'hCCDD_3344, 1);
    issue(1, 5'd7, 32'h0, LD_LWR, 32'hAABB_CCDD, 2'd1, 32'h1122_3344, 0, 0, 0, 32'h11AA_BBCC, 1);
    issue(1, 5'd7, 32'h0, LD_LWL, 32'hAABB_CCDD, 2'd0, 32'h1122_3344, 0, 0, 0, 32'hDD22_3344, 1);
    issue(1, 5'd7, 32'h0, LD_LWL, 32'hAABB_CCDD, 2'd3, 32'h1122_3344, 0, 0, 0, 32'hAABB_CCDD, 1);
    issue(1, 5'd7, 32'h0, LD_LWR, 32'hAABB_CCDD, 2'd0, 32'h1122_3344, 0, 0, 0, 32'hAABB_CCDD, 1);
    issue(1, 5'd7, 32'h0, LD_LWR, 32'hAABB_CCDD, 2'd3, 32'h1122_3344, 0, 0, 0, 32'h1122_33AA, 1);
    // GPR and HI/LO in the same op.
    issue(1, 5'd31, 32'hCAFE_F00D, LD_NONE, 32'h0, 2'd0, 32'h0, 1, 32'h0101_0101, 32'h0202_0202, 32'hCAFE_F00D, 1);
    idle(2);
    chk_ret("loads");

    // Write to $0: no rf_we, still retired.
    issue(1, 5'd0, 32'h5, LD_NONE, 32'h0, 2'd0, 32'h0, 0, 0, 0, 32'h5, 1);
    chk("zero_reg_we", {31'h0, rf_we}, 32'h0);
    idle(2);
    chk_ret("zero_reg");

    // Stall for 3 cycles after accepting A, with B waiting in MEM.
    issue(1, 5'd8, 32'h0000_0077, LD_NONE, 32'h0, 2'd0, 32'h0, 0, 0, 0, 32'h0000_0077, 1);
    set_in(1, 5'd9, 32'h0000_0088, LD_NONE, 32'h0, 2'd0, 32'h0, 0, 0, 0);
    push(1, 5'd9, 32'h0000_0088, 0, 0, 0);
    stall = 1'b1;
    idle(1);
    chk("stall_no_double", {31'h0, rf_we}, 32'h0);
    idle(2);
    stall = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    exp_ret++;
    // flush together with stall, then flush alone: neither commits.
    set_in(1, 5'd10, 32'h0000_0099, LD_NONE, 32'h0, 2'd0, 32'h0, 1, 32'h1, 32'h2);
    flush = 1'b1; stall = 1'b1;
    idle(1);
    stall = 1'b0;
    idle(1);
    flush = 1'b0; mem_valid = 1'b0;
    chk("flush_no_commit", {31'h0, rf_we | hilo_we}, 32'h0);
    idle(2);
    chk_ret("stall_flush");

    // Reset asserted during a commit cycle suppresses the write.
    issue(1, 5'd11, 32'h0000_0BAD, LD_NONE, 32'h0, 2'd0, 32'h0, 1, 32'h3, 32'h4, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_we", {31'h0, rf_we | hilo_we}, 32'h0);
    chk("midreset_cnt", retired_cnt, 32'h0);
    exp_ret = 0;
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // 17 back-to-back ops: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++)
      issue(1, 5'((i % 31) + 1), 32'h100 + i, LD_NONE, 32'h0, 2'd0, 32'h0, 0, 0, 0, 32'h100 + i, 1);
    idle(1);
    chk("wrap_cnt4", {28'h0, retired_cnt_b}, 32'h1);
    chk("wrap_cnt32", retired_cnt, 32'd17);

    // HI/LO write: present on the default instance, absent without HI/LO.
    issue(0, 5'd0, 32'h0, LD_NONE, 32'h0, 2'd0, 32'h0, 1, 32'hDEAD_0001, 32'hBEEF_0002, 32'h0, 1);
    chk("hilo_present", {31'h0, hilo_we}, 32'h1);
    chk("hilo_absent", {31'h0, hilo_we_b}, 32'h0);
    chk("hilo_absent_data", hi_wdata_b | lo_wdata_b, 32'h0);
    idle(3);
    chk_ret("final");
    chk("scoreboard_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
